// File: rtl/l1d_sched_pkg.sv
// Shared types for the L1D request issue scheduler.
// Slot state encoding and the per-slot storage record.
package l1d_sched_pkg;

    // Widest payload a slot can hold; the scheduler uses the low PAYLOAD_W bits.
    localparam int SLOT_PAYLOAD_W = 64;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        WAIT   = 2'd1,
        READY  = 2'd2,
        ISSUED = 2'd3
    } slot_state_e;

    typedef struct packed {
        slot_state_e               state;
        logic [SLOT_PAYLOAD_W-1:0] payload;
    } req_slot_t;

endpackage

// File: rtl/l1d_req_issue_sched_age.sv
// Age-order selector: an age matrix over ENTRY_COUNT slots.
// older[j][i] set means slot j was enqueued before slot i.
module age_order_selector #(
    parameter int ENTRY_COUNT = 8,
    parameter int ENQ_WIDTH   = 1,
    parameter int DEQ_WIDTH   = 1,
    parameter int SEL_WIDTH   = 1,
    localparam int TAG_W      = $clog2(ENTRY_COUNT)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [ENQ_WIDTH-1:0]             enq_vld,
    input  logic [ENQ_WIDTH*TAG_W-1:0]       enq_tag,
    input  logic [DEQ_WIDTH-1:0]             deq_vld,
    input  logic [DEQ_WIDTH*TAG_W-1:0]       deq_tag,
    input  logic [ENTRY_COUNT-1:0]           sel_mask,
    output logic [SEL_WIDTH-1:0]             sel_vld,
    output logic [SEL_WIDTH*ENTRY_COUNT-1:0] sel_onehot
);

    logic [ENTRY_COUNT-1:0]                  live_q;
    logic [ENTRY_COUNT-1:0]                  live_d;
    logic [ENTRY_COUNT-1:0][ENTRY_COUNT-1:0] older_q;
    logic [ENTRY_COUNT-1:0][ENTRY_COUNT-1:0] older_d;
    logic [TAG_W-1:0]                        t;
    logic [ENTRY_COUNT-1:0]                  pool;
    logic [ENTRY_COUNT-1:0]                  pick;
    logic                                    blocked;

    // Next matrix: dequeues drop a row/column, enqueues become youngest.
    always_comb begin
        live_d  = live_q;
        older_d = older_q;
        t       = '0;
        for (int d = 0; d < DEQ_WIDTH; d++) begin
            if (deq_vld[d]) begin
                t          = deq_tag[d*TAG_W +: TAG_W];
                live_d[t]  = 1'b0;
                older_d[t] = '0;
                for (int j = 0; j < ENTRY_COUNT; j++) begin
                    older_d[j][t] = 1'b0;
                end
            end
        end
        for (int e = 0; e < ENQ_WIDTH; e++) begin
            if (enq_vld[e]) begin
                t          = enq_tag[e*TAG_W +: TAG_W];
                older_d[t] = '0;
                for (int j = 0; j < ENTRY_COUNT; j++) begin
                    older_d[j][t] = live_d[j];
                end
                live_d[t] = 1'b1;
            end
        end
        if (flush) begin
            live_d  = '0;
            older_d = '0;
        end
    end

    // Matrix and liveness registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            live_q  <= '0;
            older_q <= '0;
        end else begin
            live_q  <= live_d;
            older_q <= older_d;
        end
    end

    // Pick the oldest masked slot, then the next oldest, per select lane.
    always_comb begin
        pool       = sel_mask & live_q;
        pick       = '0;
        blocked    = 1'b0;
        sel_vld    = '0;
        sel_onehot = '0;
        for (int s = 0; s < SEL_WIDTH; s++) begin
            pick = '0;
            for (int i = 0; i < ENTRY_COUNT; i++) begin
                blocked = 1'b0;
                for (int j = 0; j < ENTRY_COUNT; j++) begin
                    if (pool[j] && older_q[j][i]) blocked = 1'b1;
                end
                if (pool[i] && !blocked) pick[i] = 1'b1;
            end
            sel_onehot[s*ENTRY_COUNT +: ENTRY_COUNT] = pick;
            sel_vld[s] = |pick;
            pool = pool & ~pick;
        end
    end

endmodule

// File: rtl/l1d_req_issue_sched.sv
// L1D miss/replay request scheduler: slot table, oldest-ready
// issue through one output register, retire/replay on response.
module l1d_req_issue_sched
    import l1d_sched_pkg::*;
#(
    parameter int ENTRY_COUNT = 8,
    parameter int PAYLOAD_W   = 64,
    localparam int TAG_W      = $clog2(ENTRY_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc_vld_i,
    input  logic                 alloc_wait_i,
    input  logic [PAYLOAD_W-1:0] alloc_payload_i,
    output logic                 alloc_rdy_o,
    output logic [TAG_W-1:0]     alloc_tag_o,
    input  logic                 wake_vld_i,
    input  logic [TAG_W-1:0]     wake_tag_i,
    output logic                 issue_vld_o,
    input  logic                 issue_rdy_i,
    output logic [TAG_W-1:0]     issue_tag_o,
    output logic [PAYLOAD_W-1:0] issue_payload_o,
    input  logic                 resp_vld_i,
    input  logic [TAG_W-1:0]     resp_tag_i,
    input  logic                 resp_replay_i,
    input  logic                 flush_i,
    output logic [TAG_W:0]       occupancy_o,
    output logic                 empty_o
);

    function automatic logic [TAG_W-1:0] lowest_set(
        input logic [ENTRY_COUNT-1:0] vec
    );
        lowest_set = '0;
        for (int i = ENTRY_COUNT - 1; i >= 0; i--) begin
            if (vec[i]) lowest_set = TAG_W'(i);
        end
    endfunction

    function automatic logic [TAG_W-1:0] onehot_idx(
        input logic [ENTRY_COUNT-1:0] vec
    );
        onehot_idx = '0;
        for (int i = 0; i < ENTRY_COUNT; i++) begin
            if (vec[i]) onehot_idx = onehot_idx | TAG_W'(i);
        end
    endfunction

    req_slot_t              slots_q [ENTRY_COUNT];
    req_slot_t              slots_d [ENTRY_COUNT];
    logic [ENTRY_COUNT-1:0] free_vec;
    logic [ENTRY_COUNT-1:0] ready_vec;
    logic [ENTRY_COUNT-1:0] sel_onehot;
    logic                   sel_vld;
    logic [TAG_W-1:0]       sel_tag;
    slot_state_e            resp_state;
    logic                   alloc_fire;
    logic                   retire;
    logic                   handshake;
    logic                   can_load;
    logic                   load_sel;
    logic                   load_byp;
    logic                   out_vld_q;
    logic [TAG_W-1:0]       out_tag_q;
    logic [PAYLOAD_W-1:0]   out_payload_q;
    logic [TAG_W:0]         occ_q;

    // Free and ready masks from registered slot state.
    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < ENTRY_COUNT; i++) begin
            free_vec[i]  = slots_q[i].state == FREE;
            ready_vec[i] = slots_q[i].state == READY;
        end
    end

    assign alloc_rdy_o = rst_n & (|free_vec) & ~flush_i;
    assign alloc_tag_o = lowest_set(free_vec);
    assign alloc_fire  = alloc_vld_i & alloc_rdy_o;
    assign resp_state  = slots_q[resp_tag_i].state;
    assign retire      = resp_vld_i & ~resp_replay_i & (resp_state == ISSUED);
    assign handshake   = out_vld_q & issue_rdy_i;
    assign can_load    = ~out_vld_q | issue_rdy_i;
    assign load_sel    = sel_vld & can_load;
    // A fresh READY alloc is the youngest, so it only bypasses when nothing older is ready.
    assign load_byp    = alloc_fire & ~alloc_wait_i & ~sel_vld & can_load;
    assign sel_tag     = onehot_idx(sel_onehot);

    age_order_selector #(
        .ENTRY_COUNT (ENTRY_COUNT),
        .ENQ_WIDTH   (1),
        .DEQ_WIDTH   (1),
        .SEL_WIDTH   (1)
    ) u_age (
        .clk        (clk),
        .rst        (~rst_n),
        .flush      (flush_i),
        .enq_vld    (alloc_fire),
        .enq_tag    (alloc_tag_o),
        .deq_vld    (retire),
        .deq_tag    (resp_tag_i),
        .sel_mask   (ready_vec),
        .sel_vld    (sel_vld),
        .sel_onehot (sel_onehot)
    );

    // Per-slot next state; flush overrides every other update.
    always_comb begin
        for (int i = 0; i < ENTRY_COUNT; i++) begin
            slots_d[i] = slots_q[i];
            if (alloc_fire && alloc_tag_o == TAG_W'(i)) begin
                slots_d[i].payload = '0;
                slots_d[i].payload[PAYLOAD_W-1:0] = alloc_payload_i;
                if (alloc_wait_i)  slots_d[i].state = WAIT;
                else if (load_byp) slots_d[i].state = ISSUED;
                else               slots_d[i].state = READY;
            end
            if (wake_vld_i && wake_tag_i == TAG_W'(i) &&
                slots_q[i].state == WAIT) begin
                slots_d[i].state = READY;
            end
            if (load_sel && sel_onehot[i]) slots_d[i].state = ISSUED;
            if (resp_vld_i && resp_tag_i == TAG_W'(i) &&
                slots_q[i].state == ISSUED) begin
                if (!resp_replay_i)
                    slots_d[i].state = FREE;
                else if (wake_vld_i && wake_tag_i == TAG_W'(i))
                    slots_d[i].state = READY;
                else
                    slots_d[i].state = WAIT;
            end
            if (flush_i) slots_d[i].state = FREE;
        end
    end

    // Slot table registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRY_COUNT; i++) begin
            if (!rst_n) slots_q[i] <= '{state: FREE, payload: '0};
            else        slots_q[i] <= slots_d[i];
        end
    end

    // Output register: holds while stalled, reloads on empty or handshake.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            out_vld_q     <= 1'b0;
            out_tag_q     <= '0;
            out_payload_q <= '0;
        end else if (load_sel) begin
            out_vld_q     <= 1'b1;
            out_tag_q     <= sel_tag;
            out_payload_q <= slots_q[sel_tag].payload[PAYLOAD_W-1:0];
        end else if (load_byp) begin
            out_vld_q     <= 1'b1;
            out_tag_q     <= alloc_tag_o;
            out_payload_q <= alloc_payload_i;
        end else if (handshake) begin
            out_vld_q     <= 1'b0;
            out_tag_q     <= '0;
            out_payload_q <= '0;
        end
    end

    // Occupancy counter: alloc adds, retire subtracts.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i)
            occ_q <= '0;
        else if (alloc_fire && !retire)
            occ_q <= occ_q + 1'b1;
        else if (!alloc_fire && retire)
            occ_q <= occ_q - 1'b1;
    end

    assign issue_vld_o     = out_vld_q;
    assign issue_tag_o     = out_tag_q;
    assign issue_payload_o = out_payload_q;
    assign occupancy_o     = occ_q;
    assign empty_o         = occ_q == '0;

    resp_legal: assert property (@(posedge clk) disable iff (!rst_n)
        resp_vld_i |-> resp_state == ISSUED &&
                       !(out_vld_q && out_tag_q == resp_tag_i));

    occ_no_wrap: assert property (@(posedge clk) disable iff (!rst_n)
        (alloc_fire && !retire) |-> occ_q != (TAG_W+1)'(ENTRY_COUNT));

    occ_no_under: assert property (@(posedge clk) disable iff (!rst_n)
        (retire && !alloc_fire) |-> occ_q != '0);

endmodule

// File: tb/tb_l1d_req_issue_sched.sv
// Bench for l1d_req_issue_sched: directed vector table, reset
// sequences, and random traffic against a queue-based age model.
module tb_l1d_req_issue_sched;

    localparam int N  = 8;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alloc_vld_i;
    logic          alloc_wait_i;
    logic [63:0]   alloc_payload_i;
    logic          alloc_rdy_o;
    logic [TW-1:0] alloc_tag_o;
    logic          wake_vld_i;
    logic [TW-1:0] wake_tag_i;
    logic          issue_vld_o;
    logic          issue_rdy_i;
    logic [TW-1:0] issue_tag_o;
    logic [63:0]   issue_payload_o;
    logic          resp_vld_i;
    logic [TW-1:0] resp_tag_i;
    logic          resp_replay_i;
    logic          flush_i;
    logic [TW:0]   occupancy_o;
    logic          empty_o;

    always #5 clk = ~clk;

    l1d_req_issue_sched #(.ENTRY_COUNT(N), .PAYLOAD_W(64)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alloc_vld_i     (alloc_vld_i),
        .alloc_wait_i    (alloc_wait_i),
        .alloc_payload_i (alloc_payload_i),
        .alloc_rdy_o     (alloc_rdy_o),
        .alloc_tag_o     (alloc_tag_o),
        .wake_vld_i      (wake_vld_i),
        .wake_tag_i      (wake_tag_i),
        .issue_vld_o     (issue_vld_o),
        .issue_rdy_i     (issue_rdy_i),
        .issue_tag_o     (issue_tag_o),
        .issue_payload_o (issue_payload_o),
        .resp_vld_i      (resp_vld_i),
        .resp_tag_i      (resp_tag_i),
        .resp_replay_i   (resp_replay_i),
        .flush_i         (flush_i),
        .occupancy_o     (occupancy_o),
        .empty_o         (empty_o)
    );

    typedef struct {
        bit av; bit aw; logic [63:0] ap;
        bit wv; logic [TW-1:0] wt;
        bit ir;
        bit rv; logic [TW-1:0] rt; bit rr;
        bit fl;
        bit eiv; logic [TW-1:0] eit; logic [63:0] eip;
        logic [TW:0] eocc; bit eardy; logic [TW-1:0] eatag;
    } vec_t;

    vec_t tbl[$];
    int total  = 0;
    int passed = 0;

    // Slot states in the reference model.
    localparam int SF = 0, SW = 1, SR = 2, SI = 3;
    int          m_st [N];
    logic [63:0] m_pay [N];
    int          m_age[$];
    bit          m_ov;
    int          m_ot;
    logic [63:0] m_op;
    int          m_occ;

    function automatic vec_t mk(int av, int aw, int ap, int wv, int wt,
                                int ir, int rv, int rt, int rr, int fl,
                                int eiv, int eit, int eip, int eocc,
                                int eardy, int eatag);
        vec_t v;
        v.av = av[0]; v.aw = aw[0]; v.ap = 64'(ap);
        v.wv = wv[0]; v.wt = wt[TW-1:0]; v.ir = ir[0];
        v.rv = rv[0]; v.rt = rt[TW-1:0]; v.rr = rr[0]; v.fl = fl[0];
        v.eiv = eiv[0]; v.eit = eit[TW-1:0]; v.eip = 64'(eip);
        v.eocc = eocc[TW:0]; v.eardy = eardy[0]; v.eatag = eatag[TW-1:0];
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        else
            passed++;
    endtask

    task automatic idle();
        alloc_vld_i = 0; alloc_wait_i = 0; alloc_payload_i = '0;
        wake_vld_i = 0; wake_tag_i = '0; issue_rdy_i = 0;
        resp_vld_i = 0; resp_tag_i = '0; resp_replay_i = 0; flush_i = 0;
    endtask

    task automatic apply(vec_t v, int k);
        alloc_vld_i = v.av; alloc_wait_i = v.aw; alloc_payload_i = v.ap;
        wake_vld_i = v.wv; wake_tag_i = v.wt; issue_rdy_i = v.ir;
        resp_vld_i = v.rv; resp_tag_i = v.rt; resp_replay_i = v.rr;
        flush_i = v.fl;
        @(posedge clk); #1;
        idle();
        #1;
        chk($sformatf("v%0d_ivld", k), 64'(issue_vld_o), 64'(v.eiv));
        if (v.eiv) begin
            chk($sformatf("v%0d_itag", k), 64'(issue_tag_o), 64'(v.eit));
            chk($sformatf("v%0d_ipay", k), issue_payload_o, v.eip);
        end
        chk($sformatf("v%0d_occ", k), 64'(occupancy_o), 64'(v.eocc));
        chk($sformatf("v%0d_empty", k), 64'(empty_o), 64'(v.eocc == 0));
        chk($sformatf("v%0d_ardy", k), 64'(alloc_rdy_o), 64'(v.eardy));
        if (v.eardy)
            chk($sformatf("v%0d_atag", k), 64'(alloc_tag_o), 64'(v.eatag));
    endtask

    task automatic rand_step(int k);
        int cands[$];
        int lf, cand, idx;
        int old_st [N];
        bit prdy, fire, byp, can;
        alloc_vld_i     = 1'($urandom_range(0, 1));
        alloc_wait_i    = ($urandom_range(0, 2) == 0);
        alloc_payload_i = {$urandom, $urandom};
        wake_vld_i      = ($urandom_range(0, 2) == 0);
        wake_tag_i      = TW'($urandom_range(0, N - 1));
        issue_rdy_i     = ($urandom_range(0, 3) != 0);
        flush_i         = ($urandom_range(0, 49) == 0);
        for (int t = 0; t < N; t++)
            if (m_st[t] == SI && !(m_ov && m_ot == t)) cands.push_back(t);
        resp_vld_i    = (cands.size() > 0) && ($urandom_range(0, 1) == 1);
        resp_tag_i    = '0;
        resp_replay_i = ($urandom_range(0, 2) == 0);
        if (resp_vld_i)
            resp_tag_i = TW'(cands[$urandom_range(0, cands.size() - 1)]);
        #1;
        lf = -1;
        for (int t = 0; t < N; t++)
            if (m_st[t] == SF && lf < 0) lf = t;
        prdy = (lf >= 0) && !flush_i;
        chk($sformatf("r%0d_ardy", k), 64'(alloc_rdy_o), 64'(prdy));
        if (prdy)
            chk($sformatf("r%0d_atag", k), 64'(alloc_tag_o), 64'(lf));
        chk($sformatf("r%0d_ivld", k), 64'(issue_vld_o), 64'(m_ov));
        if (m_ov) begin
            chk($sformatf("r%0d_itag", k), 64'(issue_tag_o), 64'(m_ot));
            chk($sformatf("r%0d_ipay", k), issue_payload_o, m_op);
        end
        chk($sformatf("r%0d_occ", k), 64'(occupancy_o), 64'(m_occ));
        chk($sformatf("r%0d_empty", k), 64'(empty_o), 64'(m_occ == 0));
        if (flush_i) begin
            for (int t = 0; t < N; t++) m_st[t] = SF;
            m_age.delete();
            m_ov = 0; m_occ = 0;
        end else begin
            fire   = alloc_vld_i && prdy;
            old_st = m_st;
            cand   = -1;
            byp    = 0;
            foreach (m_age[a])
                if (cand < 0 && old_st[m_age[a]] == SR) cand = m_age[a];
            if (cand < 0 && fire && !alloc_wait_i) begin
                cand = lf; byp = 1;
            end
            can = !m_ov || issue_rdy_i;
            if (can && cand >= 0) begin
                m_ov = 1; m_ot = cand;
                m_op = byp ? alloc_payload_i : m_pay[cand];
            end else if (m_ov && issue_rdy_i) begin
                m_ov = 0;
            end
            if (wake_vld_i && old_st[wake_tag_i] == SW) m_st[wake_tag_i] = SR;
            if (resp_vld_i) begin
                if (resp_replay_i) begin
                    m_st[resp_tag_i] = (wake_vld_i && wake_tag_i == resp_tag_i) ? SR : SW;
                end else begin
                    m_st[resp_tag_i] = SF;
                    idx = -1;
                    foreach (m_age[a]) if (m_age[a] == int'(resp_tag_i)) idx = a;
                    if (idx >= 0) m_age.delete(idx);
                    m_occ--;
                end
            end
            if (fire) begin
                m_st[lf] = alloc_wait_i ? SW : SR;
                m_pay[lf] = alloc_payload_i;
                m_age.push_back(lf);
                m_occ++;
            end
            if (can && cand >= 0) m_st[cand] = SI;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        //             av aw ap    wv wt ir rv rt rr fl  eiv eit eip  occ rdy atag
        tbl.push_back(mk(0,0,0,     0,0, 1, 0,0,0, 0,  0,0,0,     0,1,0));
        tbl.push_back(mk(1,0,'hA5,  0,0, 1, 0,0,0, 0,  1,0,'hA5,  1,1,1));
        tbl.push_back(mk(0,0,0,     0,0, 1, 0,0,0, 0,  0,0,0,     1,1,1));
        tbl.push_back(mk(0,0,0,     0,0, 0, 1,0,0, 0,  0,0,0,     0,1,0));
        tbl.push_back(mk(1,1,'h10,  0,0, 0, 0,0,0, 0,  0,0,0,     1,1,1));
        tbl.push_back(mk(1,0,'h11,  0,0, 0, 0,0,0, 0,  1,1,'h11,  2,1,2));
        tbl.push_back(mk(0,0,0,     1,0, 1, 0,0,0, 0,  0,0,0,     2,1,2));
        tbl.push_back(mk(0,0,0,     0,0, 1, 0,0,0, 0,  1,0,'h10,  2,1,2));
        tbl.push_back(mk(0,0,0,     0,0, 1, 1,1,1, 0,  0,0,0,     2,1,2));
        tbl.push_back(mk(1,0,'h12,  0,0, 0, 0,0,0, 0,  1,2,'h12,  3,1,3));
        tbl.push_back(mk(1,0,'h13,  0,0, 0, 0,0,0, 0,  1,2,'h12,  4,1,4));
        tbl.push_back(mk(0,0,0,     1,1, 0, 0,0,0, 0,  1,2,'h12,  4,1,4));
        tbl.push_back(mk(0,0,0,     0,0, 1, 0,0,0, 0,  1,1,'h11,  4,1,4));
        tbl.push_back(mk(0,0,0,     0,0, 1, 0,0,0, 0,  1,3,'h13,  4,1,4));
        tbl.push_back(mk(0,0,0,     0,0, 1, 0,0,0, 0,  0,0,0,     4,1,4));
        tbl.push_back(mk(0,0,0,     0,0, 0, 1,0,0, 0,  0,0,0,     3,1,0));
        tbl.push_back(mk(0,0,0,     0,0, 0, 1,1,0, 0,  0,0,0,     2,1,0));
        tbl.push_back(mk(0,0,0,     0,0, 0, 1,2,0, 0,  0,0,0,     1,1,0));
        tbl.push_back(mk(0,0,0,     0,0, 0, 1,3,0, 0,  0,0,0,     0,1,0));
        tbl.push_back(mk(1,0,'h20,  0,0, 0, 0,0,0, 0,  1,0,'h20,  1,1,1));
        tbl.push_back(mk(1,0,'h21,  0,0, 0, 0,0,0, 0,  1,0,'h20,  2,1,2));
        tbl.push_back(mk(1,0,'h22,  0,0, 0, 0,0,0, 0,  1,0,'h20,  3,1,3));
        tbl.push_back(mk(0,0,0,     0,0, 0, 0,0,0, 0,  1,0,'h20,  3,1,3));
        tbl.push_back(mk(0,0,0,     0,0, 0, 0,0,0, 0,  1,0,'h20,  3,1,3));
        tbl.push_back(mk(0,0,0,     0,0, 0, 0,0,0, 0,  1,0,'h20,  3,1,3));
        tbl.push_back(mk(0,0,0,     0,0, 1, 0,0,0, 0,  1,1,'h21,  3,1,3));
        tbl.push_back(mk(0,0,0,     0,0, 1, 0,0,0, 0,  1,2,'h22,  3,1,3));
        tbl.push_back(mk(0,0,0,     0,0, 1, 0,0,0, 0,  0,0,0,     3,1,3));
        tbl.push_back(mk(1,0,'h30,  0,0, 0, 0,0,0, 0,  1,3,'h30,  4,1,4));
        tbl.push_back(mk(1,0,'h31,  0,0, 0, 0,0,0, 0,  1,3,'h30,  5,1,5));
        tbl.push_back(mk(1,0,'h32,  0,0, 0, 0,0,0, 0,  1,3,'h30,  6,1,6));
        tbl.push_back(mk(1,0,'h33,  0,0, 0, 0,0,0, 0,  1,3,'h30,  7,1,7));
        tbl.push_back(mk(1,0,'h34,  0,0, 0, 0,0,0, 0,  1,3,'h30,  8,0,0));
        tbl.push_back(mk(0,0,0,     0,0, 1, 0,0,0, 0,  1,4,'h31,  8,0,0));
        tbl.push_back(mk(0,0,0,     0,0, 1, 0,0,0, 0,  1,5,'h32,  8,0,0));
        tbl.push_back(mk(0,0,0,     0,0, 1, 0,0,0, 0,  1,6,'h33,  8,0,0));
        tbl.push_back(mk(0,0,0,     0,0, 0, 1,5,0, 0,  1,6,'h33,  7,1,5));
        tbl.push_back(mk(1,0,'h99,  0,0, 1, 0,0,0, 1,  0,0,0,     0,1,0));

        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ardy", 64'(alloc_rdy_o), 64'(0));
        chk("rst_ivld", 64'(issue_vld_o), 64'(0));
        chk("rst_itag", 64'(issue_tag_o), 64'(0));
        chk("rst_ipay", issue_payload_o, 64'(0));
        chk("rst_occ", 64'(occupancy_o), 64'(0));
        chk("rst_empty", 64'(empty_o), 64'(1));
        rst_n = 1'b1;
        #1;
        chk("post_rst_ardy", 64'(alloc_rdy_o), 64'(1));
        chk("post_rst_atag", 64'(alloc_tag_o), 64'(0));

        foreach (tbl[k]) apply(tbl[k], k);

        for (int k = 0; k < 3; k++) begin
            alloc_vld_i = 1; alloc_wait_i = 0;
            alloc_payload_i = 64'(64 + k); issue_rdy_i = 0;
            @(posedge clk); #1;
        end
        idle();
        chk("mid_pre_occ", 64'(occupancy_o), 64'(3));
        chk("mid_pre_ivld", 64'(issue_vld_o), 64'(1));
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_ivld", 64'(issue_vld_o), 64'(0));
        chk("mid_rst_itag", 64'(issue_tag_o), 64'(0));
        chk("mid_rst_ipay", issue_payload_o, 64'(0));
        chk("mid_rst_occ", 64'(occupancy_o), 64'(0));
        chk("mid_rst_empty", 64'(empty_o), 64'(1));
        chk("mid_rst_ardy", 64'(alloc_rdy_o), 64'(0));
        rst_n = 1'b1;
        issue_rdy_i = 1;
        #1;
        chk("mid_post_ardy", 64'(alloc_rdy_o), 64'(1));
        chk("mid_post_atag", 64'(alloc_tag_o), 64'(0));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("mid_stale%0d", k), 64'(issue_vld_o), 64'(0));
            chk($sformatf("mid_occ%0d", k), 64'(occupancy_o), 64'(0));
        end

        for (int t = 0; t < N; t++) begin
            m_st[t] = SF; m_pay[t] = '0;
        end
        m_age.delete();
        m_ov = 0; m_ot = 0; m_op = '0; m_occ = 0;
        for (int k = 0; k < 600; k++) rand_step(k);
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/l1d_req_issue_sched.md
Name: l1d_req_issue_sched

Overview:
- Request scheduler for the L1D miss/replay path.
- Holds up to ENTRY_COUNT outstanding requests in per-entry state slots and tracks their relative age with an internal age_order_selector instance.
- Issues the oldest ready request to a single downstream port using a valid/ready handshake.
- Retires or replays entries on response and sits between the L1D pipeline and the shared memory-request port.

Parameters:
- ENTRY_COUNT, 8, number of request slots; must be a power of two and at least 2.
- PAYLOAD_W, 64, opaque request payload width.
- TAG_W, $clog2(ENTRY_COUNT), local; slot index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- alloc_vld_i  in  1  new request valid
- alloc_wait_i  in  1  1 = enter WAIT (needs wakeup); 0 = enter READY
- alloc_payload_i  in  PAYLOAD_W  request payload
- alloc_rdy_o  out  1  free slot available; allocation occurs when alloc_vld_i & alloc_rdy_o
- alloc_tag_o  out  TAG_W  slot index granted this cycle
- wake_vld_i  in  1  wakeup valid
- wake_tag_i  in  TAG_W  slot to wake
- issue_vld_o  out  1  downstream request valid
- issue_rdy_i  in  1  downstream accepts
- issue_tag_o  out  TAG_W  slot of issued request
- issue_payload_o  out  PAYLOAD_W  payload of issued request
- resp_vld_i  in  1  response valid
- resp_tag_i  in  TAG_W  responding slot
- resp_replay_i  in  1  1 = replay (back to WAIT); 0 = retire
- flush_i  in  1  discard all entries
- occupancy_o  out  TAG_W+1  number of non-FREE slots
- empty_o  out  1  occupancy_o == 0

Behaviour:
- Interface decision: one clock (clk); reset rst_n is synchronous and active-low. The internal age_order_selector is reset with ~rst_n.
- Reset: all slots FREE, output register empty, age matrix cleared. Output values during and after reset:
  - issue_vld_o=0, issue_tag_o=0, issue_payload_o=0, occupancy_o=0, empty_o=1.
  - alloc_rdy_o=0 while rst_n=0, then 1 on the first cycle after reset.
- Slot states FREE, WAIT, READY, ISSUED; 2-bit registered state per slot plus a payload register.
- Allocation:
  - alloc_rdy_o = (any FREE slot, from registered state) & ~flush_i.
  - alloc_tag_o = lowest-index FREE slot.
  - On a fire: slot -> WAIT or READY per alloc_wait_i, payload captured, enqueue into the age selector with the same tag.
- Wakeup: WAIT -> READY. A wakeup on a non-WAIT slot is ignored and is not an error.
- Selection:
  - The age selector's select mask is the set of READY slots.
  - The oldest READY slot loads the output register when it is empty, or when issue_vld_o & issue_rdy_i.
  - Loading moves the slot READY -> ISSUED, so it cannot be selected twice.
- Latency: alloc (READY) in cycle N -> issue_vld_o=1 in cycle N+1 at the earliest.
- Handshake: while issue_vld_o=1 & issue_rdy_i=0, tag and payload are held stable. Back-to-back issue runs at 1/cycle when issue_rdy_i stays high.
- Response (only legal for an ISSUED slot whose handshake has completed):
  - Retire: ISSUED -> FREE and dequeue from the age selector.
  - Replay: ISSUED -> WAIT; the slot keeps its age and stays older than later allocations.
  - A response to any other state is ignored and flagged by a simulation assertion.
- Simultaneous events:
  - A slot freed in cycle N is not visible to allocation until N+1.
  - Replay and wake on the same tag in the same cycle -> READY.
  - Retire of slot A and allocation of slot B in the same cycle: both apply; occupancy is unchanged.
- occupancy_o is a registered counter: +1 on alloc fire, -1 on retire, both in the same cycle -> unchanged. It never wraps; an overflow assertion covers this.
- flush_i:
  - Takes priority over all same-cycle alloc, wake, response and issue updates.
  - Next cycle: all slots FREE, output register cleared (issue_vld_o=0), occupancy 0, age selector flushed.
  - An in-flight handshake in the flush cycle is dropped.
- Full: alloc_rdy_o=0 with ENTRY_COUNT slots occupied; alloc_vld_i is held off upstream.

Decomposition:
- Shared package l1d_sched_pkg holds:
  - typedef enum logic [1:0] slot_state_e {FREE, WAIT, READY, ISSUED};
  - typedef struct req_slot_t {state, payload}.
- Sub-module: the existing age_order_selector (ENQ_WIDTH=DEQ_WIDTH=SEL_WIDTH=1).
- Lowest-free-index and one-hot-to-index encoders are local functions.

Test Plan:
- Reset, then alloc READY payload 0xA5 with issue_rdy_i=1 -> alloc_tag_o=0, issue_vld_o=1 next cycle with tag 0 and payload 0xA5; resp retire -> empty_o=1.
- Alloc tags 0,1,2 READY with issue_rdy_i=0 for 5 cycles -> issue_tag_o held at 0 stable; release -> issue order 0,1,2 on consecutive cycles.
- Alloc 0 WAIT, then 1 READY, then wake 0 -> slot 1 issues first, then slot 0; replay slot 1, wake it -> slot 1 issues before a later-allocated slot 3.
- Fill all 8 slots -> alloc_rdy_o=0 and occupancy_o=8; retire tag 5 -> next cycle alloc_rdy_o=1 and alloc_tag_o=5.
- Flush with 4 slots occupied and issue_vld_o=1 -> next cycle issue_vld_o=0, occupancy_o=0, alloc_tag_o=0; a same-cycle alloc is not accepted.
- rst_n low mid-stream with 3 outstanding -> all outputs at reset values next cycle; no stale issue afterwards.
